ai_car_spawn_scheduler: RTL and testbench
=========================================

# ai_car_spawn_scheduler

Schedules re-entry of the AI traffic cars onto the road. Cars that have left the screen raise a spawn request; once per frame the scheduler grants at most one requester, round-robin, with a frame-count cooldown between spawns. Each granted car gets a lane. A lane's x position stays owned by that car until the car releases it, so two cars are never placed in the same lane. The block sits between the per-car AI modules and the random-number source, in the frame-rate domain of the VGA game logic.

## Interface
- N_CARS, 4, number of requesting AI cars (2..8)
- COOLDOWN_FRAMES, 30, frames between consecutive grants (8-bit counter)
- LANE_X0 / LANE_X1 / LANE_X2 / LANE_X3, 180 / 240 / 300 / 360, spawn x for lanes 0..3 (11-bit)

- clk  in  1  system clock; one clock for the whole block
- resetN  in  1  asynchronous, active-high reset (asserted = 1, despite the name)
- frame_start  in  1  one-cycle pulse per video frame
- game_states  in  5  bit0 = restart, bit1 = pause; bits 2..4 ignored
- random  in  11  free-running random value; only bits [1:0] (LSBs) are used
- spawn_req  in  N_CARS  level request per car; held until acked
- lane_release  in  N_CARS  one-cycle pulse; car i frees the lane it owns
- spawn_ack  out  N_CARS  one-hot, one-cycle grant pulse
- spawn_x  out  11  lane x of the current grant; holds its value between grants
- lane_busy  out  4  occupancy flag per lane
- busy  out  1  high whenever state is not IDLE

## Operation
- State: IDLE, PICK, PROBE, GRANT. Registers:
  - `owner[4]` (car index + valid, per lane)
  - `rr_ptr`
  - `cooldown`
  - `winner`
  - `probe_lane`
  - `probe_cnt` (0..3)
- **IDLE → PICK**: requires frame_start, cooldown==0, pause==0, restart==0, and |spawn_req.
  - cooldown is evaluated before it is decremented.
- **Cooldown**: on frame_start with cooldown≠0 and pause==0, cooldown decrements. It saturates at 0 and is frozen while paused.
- **PICK** (1 cycle):
  - winner = first asserted spawn_req, scanning from rr_ptr+1 mod N_CARS upward.
  - probe_lane = random[1:0]; probe_cnt = 0.
  - If no request is still asserted, go to IDLE.
- **PROBE** (1 cycle per lane):
  - If spawn_req[winner]==0, go to IDLE (abandoned, no grant).
  - Else if owner[probe_lane] is free, go to GRANT.
  - Else probe_lane = probe_lane+1 mod 4 and probe_cnt++.
  - After the 4th busy probe, go to IDLE with no grant and cooldown unchanged.
- **GRANT** (1 cycle), all registered:
  - spawn_ack[winner] = 1.
  - spawn_x = LANE_X[probe_lane].
  - Any lane already owned by winner is freed, then owner[probe_lane] = winner.
  - rr_ptr = winner; cooldown = COOLDOWN_FRAMES.
  - Next state IDLE.
- **lane_release[i]**: clears every lane owned by car i in the same cycle, in any state.
  - If it coincides with GRANT to car i, the new ownership wins.
  - A release during PROBE is visible to the next probe.
- **Restart** (game_states[0]=1), synchronous, any state:
  - state goes to IDLE; all owners cleared; cooldown = 0.
  - spawn_ack = 0; rr_ptr = N_CARS-1.
  - Takes priority over every other action that cycle.
- **Pause**: blocks only new arbitration; an in-flight PICK/PROBE/GRANT completes.
- lane_busy[k] = owner[k].valid (registered). Ownership always remains a partial injection from lanes to cars.

## Timing
- Reset values:
  - state IDLE; spawn_ack 0; spawn_x 0; lane_busy 0; busy 0.
  - cooldown 0; rr_ptr N_CARS-1 (so car 0 is first); all owners free.
- With frame_start in cycle t (in IDLE), PICK is at t+1 and the first PROBE is at t+2.
- Grant latency:
  - spawn_ack is high in cycle t+3 when the first probed lane is free.
  - It is high in cycle t+6 when the 4th lane is the first free one.
- A fully blocked attempt returns to IDLE at t+6.
- spawn_x is valid in the same cycle as spawn_ack and holds afterwards.
- lane_busy updates one cycle after a GRANT or a release.
- At most one grant per frame. The next grant requires COOLDOWN_FRAMES further frame_start pulses.
- frame_start pulses that arrive while busy are ignored for arbitration but still decrement cooldown.

## Test plan
- **Basic grant**:
  - Stimulus: after reset, random=2, spawn_req=4'b0001, frame_start at t.
  - Required: spawn_ack=4'b0001 at t+3; spawn_x=300; lane_busy=4'b0100.
- **Round-robin and cooldown** (COOLDOWN_FRAMES=2):
  - Stimulus: spawn_req=4'b1111 held.
  - Required: grants go to car 0, 1, 2, 3 in that order, exactly 3 frame_starts apart.
- **Lane probing**:
  - Stimulus: lanes 2 and 3 busy, random=2.
  - Required: ack at t+5 with spawn_x=180 (wraps to lane 0).
- **All lanes busy**:
  - Stimulus: all four lanes busy, a spawn request, frame_start.
  - Required: no ack; busy is high t+1..t+5; cooldown stays 0; a grant happens on the next frame after any lane_release.
- **Abandon**:
  - Stimulus: spawn_req drops in the first PROBE cycle.
  - Required: no ack, owners unchanged, IDLE next cycle.
- **Restart mid-PROBE**:
  - Stimulus: game_states[0]=1 during PROBE.
  - Required: IDLE next cycle, lane_busy=0, spawn_ack stays 0. Then async resetN=1 mid-GRANT: all outputs 0 immediately.

Source files
------------

// File: rtl/ai_car_spawn_scheduler_if.sv
// rtl/ai_car_spawn_scheduler_if.sv - request/grant/lane bundle between the AI cars and the spawn scheduler
interface ai_car_spawn_scheduler_if #(
   parameter int N_CARS = 4
);
   logic [N_CARS-1:0] spawn_req;
   logic [N_CARS-1:0] lane_release;
   logic [N_CARS-1:0] spawn_ack;
   logic [10:0]       spawn_x;
   logic [3:0]        lane_busy;

   modport master (
      output spawn_req,
      output lane_release,
      input  spawn_ack,
      input  spawn_x,
      input  lane_busy
   );

   modport slave (
      input  spawn_req,
      input  lane_release,
      output spawn_ack,
      output spawn_x,
      output lane_busy
   );
endinterface

// File: rtl/ai_car_spawn_scheduler.sv
// rtl/ai_car_spawn_scheduler.sv - round-robin AI car spawn arbiter with per-lane ownership
// Grants at most one car per frame, probes lanes from a random start, enforces a frame cooldown.
module ai_car_spawn_scheduler #(
   parameter int          N_CARS          = 4,
   parameter int          COOLDOWN_FRAMES = 30,
   parameter logic [10:0] LANE_X0         = 11'd180,
   parameter logic [10:0] LANE_X1         = 11'd240,
   parameter logic [10:0] LANE_X2         = 11'd300,
   parameter logic [10:0] LANE_X3         = 11'd360
) (
   input  logic        clk,
   input  logic        resetN,
   input  logic        frame_start,
   input  logic [4:0]  game_states,
   input  logic [10:0] random,
   output logic        busy,
   ai_car_spawn_scheduler_if.slave bus
);
   localparam int CW = $clog2(N_CARS);

   typedef enum logic [1:0] {IDLE, PICK, PROBE, GRANT} state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     rr_ptr_q, rr_ptr_d;
   logic [CW-1:0]     winner_q, winner_d;
   logic [7:0]        cooldown_q, cooldown_d;
   logic [1:0]        probe_lane_q, probe_lane_d;
   logic [1:0]        probe_cnt_q, probe_cnt_d;
   logic [3:0]        own_vld_q, own_vld_d;
   logic [CW-1:0]     own_car_q [4];
   logic [CW-1:0]     own_car_d [4];
   logic [N_CARS-1:0] ack_q, ack_d;
   logic [10:0]       x_q, x_d;

   logic          restart;
   logic          pause;
   logic          found;
   logic [CW-1:0] pick;
   logic [10:0]   lane_x;
   logic          unused_bits;

   assign restart     = game_states[0];
   assign pause       = game_states[1];
   assign unused_bits = ^{game_states[4:2], random[10:2]};

   always_comb begin
      case (probe_lane_q)
         2'd0:    lane_x = LANE_X0;
         2'd1:    lane_x = LANE_X1;
         2'd2:    lane_x = LANE_X2;
         default: lane_x = LANE_X3;
      endcase
   end

   // First requester strictly after the last winner, wrapping around.
   always_comb begin
      logic [CW-1:0] idx;
      found = 1'b0;
      pick  = '0;
      idx   = '0;
      for (int k = 1; k <= N_CARS; k++) begin
         idx = CW'((int'(rr_ptr_q) + k) % N_CARS);
         if (!found && bus.spawn_req[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      cooldown_d   = cooldown_q;
      winner_d     = winner_q;
      probe_lane_d = probe_lane_q;
      probe_cnt_d  = probe_cnt_q;
      ack_d        = '0;
      x_d          = x_q;
      own_vld_d    = own_vld_q;
      own_car_d    = own_car_q;

      for (int l = 0; l < 4; l++) begin
         if (bus.lane_release[own_car_q[l]]) begin
            own_vld_d[l] = 1'b0;
         end
      end

      if (frame_start && !pause && cooldown_q != 8'd0) begin
         cooldown_d = cooldown_q - 8'd1;
      end

      case (state_q)
         IDLE: begin
            if (frame_start && cooldown_q == 8'd0 && !pause && !restart && |bus.spawn_req) begin
               state_d = PICK;
            end
         end
         PICK: begin
            if (found) begin
               winner_d     = pick;
               probe_lane_d = random[1:0];
               probe_cnt_d  = 2'd0;
               state_d      = PROBE;
            end else begin
               state_d = IDLE;
            end
         end
         PROBE: begin
            if (!bus.spawn_req[winner_q]) begin
               state_d = IDLE;
            end else if (!own_vld_q[probe_lane_q]) begin
               ack_d[winner_q] = 1'b1;
               x_d             = lane_x;
               state_d         = GRANT;
            end else if (probe_cnt_q == 2'd3) begin
               state_d = IDLE;
            end else begin
               probe_lane_d = probe_lane_q + 2'd1;
               probe_cnt_d  = probe_cnt_q + 2'd1;
            end
         end
         GRANT: begin
            // Applied after releases so a simultaneous release by the winner cannot undo its new lane.
            for (int l = 0; l < 4; l++) begin
               if (own_car_q[l] == winner_q) begin
                  own_vld_d[l] = 1'b0;
               end
            end
            own_vld_d[probe_lane_q] = 1'b1;
            own_car_d[probe_lane_q] = winner_q;
            rr_ptr_d                = winner_q;
            cooldown_d              = 8'(COOLDOWN_FRAMES);
            state_d                 = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (restart) begin
         state_d    = IDLE;
         own_vld_d  = '0;
         cooldown_d = 8'd0;
         ack_d      = '0;
         rr_ptr_d   = CW'(N_CARS - 1);
      end
   end

   always_ff @(posedge clk or posedge resetN) begin
      if (resetN) begin
         state_q      <= IDLE;
         rr_ptr_q     <= CW'(N_CARS - 1);
         cooldown_q   <= 8'd0;
         winner_q     <= '0;
         probe_lane_q <= 2'd0;
         probe_cnt_q  <= 2'd0;
         own_vld_q    <= '0;
         own_car_q    <= '{default: '0};
         ack_q        <= '0;
         x_q          <= 11'd0;
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         cooldown_q   <= cooldown_d;
         winner_q     <= winner_d;
         probe_lane_q <= probe_lane_d;
         probe_cnt_q  <= probe_cnt_d;
         own_vld_q    <= own_vld_d;
         own_car_q    <= own_car_d;
         ack_q        <= ack_d;
         x_q          <= x_d;
      end
   end

   assign bus.spawn_ack = ack_q;
   assign bus.spawn_x   = x_q;
   assign bus.lane_busy = own_vld_q;
   assign busy          = (state_q != IDLE);
endmodule

// File: tb/tb_ai_car_spawn_scheduler.sv
// tb/tb_ai_car_spawn_scheduler.sv - self-checking bench for ai_car_spawn_scheduler
// Grant table plus hand sequences; expected grants queued at stimulus time and matched on spawn_ack.
module tb_ai_car_spawn_scheduler;
   logic        clk = 1'b0;
   logic        resetN = 1'b1;
   logic        frame_start = 1'b0;
   logic [4:0]  game_states = 5'd0;
   logic [10:0] random = 11'd0;
   logic        busy;
   int          cyc = 0;
   int          checks = 0;
   int          failures = 0;

   ai_car_spawn_scheduler_if #(.N_CARS(4)) bus ();

   ai_car_spawn_scheduler #(.N_CARS(4), .COOLDOWN_FRAMES(2)) dut (
      .clk         (clk),
      .resetN      (resetN),
      .frame_start (frame_start),
      .game_states (game_states),
      .random      (random),
      .busy        (busy),
      .bus         (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [3:0]  rel;
      logic [3:0]  req;
      logic [1:0]  rnd;
      logic [3:0]  ack;
      logic [10:0] x;
      int          lat;
      logic [3:0]  lbusy;
   } vec_t;

   typedef struct {
      logic [3:0]  ack;
      logic [10:0] x;
      int          cyc;
   } exp_t;

   vec_t        tbl [8];
   exp_t        sb [$];
   exp_t        mon_e;
   logic [10:0] lx [4];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_frame(output int t);
      @(posedge clk);
      #1;
      frame_start = 1'b1;
      t = cyc;
      @(posedge clk);
      #1;
      frame_start = 1'b0;
   endtask

   task automatic push_exp(input logic [3:0] ack, input logic [10:0] x, input int c);
      exp_t e;
      e.ack = ack;
      e.x   = x;
      e.cyc = c;
      sb.push_back(e);
   endtask

   task automatic do_reset();
      resetN           = 1'b1;
      frame_start      = 1'b0;
      game_states      = 5'd0;
      random           = 11'd0;
      bus.spawn_req    = 4'd0;
      bus.lane_release = 4'd0;
      step(3);
      resetN = 1'b0;
      step(1);
   endtask

   always @(negedge clk) begin
      if (bus.spawn_ack !== 4'd0) begin
         if (sb.size() == 0) begin
            chk("unexpected_ack", int'(bus.spawn_ack), 0);
         end else begin
            mon_e = sb.pop_front();
            chk("ack", int'(bus.spawn_ack), int'(mon_e.ack));
            chk("spawn_x", int'(bus.spawn_x), int'(mon_e.x));
            chk("ack_cycle", cyc, mon_e.cyc);
         end
      end
   end

   initial begin
      int         t;
      logic [5:0] bvec;

      lx[0] = 11'd180;
      lx[1] = 11'd240;
      lx[2] = 11'd300;
      lx[3] = 11'd360;
      //           rel      req      rnd   ack      x        lat lane_busy
      tbl[0] = '{4'b0000, 4'b0001, 2'd2, 4'b0001, 11'd300, 3, 4'b0100};
      tbl[1] = '{4'b0000, 4'b1111, 2'd2, 4'b0010, 11'd360, 4, 4'b1100};
      tbl[2] = '{4'b0000, 4'b1111, 2'd2, 4'b0100, 11'd180, 5, 4'b1101};
      tbl[3] = '{4'b0000, 4'b1111, 2'd2, 4'b1000, 11'd240, 6, 4'b1111};
      tbl[4] = '{4'b0001, 4'b0001, 2'd1, 4'b0001, 11'd300, 4, 4'b1111};
      tbl[5] = '{4'b0100, 4'b0010, 2'd0, 4'b0010, 11'd180, 3, 4'b0111};
      tbl[6] = '{4'b0000, 4'b1001, 2'd3, 4'b1000, 11'd360, 3, 4'b1101};
      tbl[7] = '{4'b0000, 4'b0011, 2'd1, 4'b0001, 11'd240, 3, 4'b1011};

      do_reset();
      chk("reset_ack", int'(bus.spawn_ack), 0);
      chk("reset_x", int'(bus.spawn_x), 0);
      chk("reset_lane_busy", int'(bus.lane_busy), 0);
      chk("reset_busy", int'(busy), 0);

      for (int i = 0; i < 8; i++) begin
         bus.spawn_req    = 4'd0;
         bus.lane_release = tbl[i].rel;
         step(1);
         bus.lane_release = 4'd0;
         pulse_frame(t);
         step(6);
         pulse_frame(t);
         step(6);
         random        = {9'd0, tbl[i].rnd};
         bus.spawn_req = tbl[i].req;
         pulse_frame(t);
         push_exp(tbl[i].ack, tbl[i].x, t + tbl[i].lat);
         step(7);
         bus.spawn_req = 4'd0;
         chk("tbl_grant_seen", sb.size(), 0);
         chk("tbl_lane_busy", int'(bus.lane_busy), int'(tbl[i].lbusy));
      end

      // Round robin with cooldown of 2: grants on every third frame, each probe wrapping one lane further.
      do_reset();
      bus.spawn_req = 4'b1111;
      random        = 11'd0;
      for (int f = 0; f < 12; f++) begin
         pulse_frame(t);
         if (f % 3 == 0) begin
            push_exp(4'(1 << (f / 3)), lx[f / 3], t + 3 + f / 3);
         end
         step(8);
      end
      chk("rr_grants_seen", sb.size(), 0);

      // All four lanes owned: full probe with no grant, busy for exactly five cycles.
      pulse_frame(t);
      bvec = 6'd0;
      for (int k = 0; k < 6; k++) begin
         bvec = {busy, bvec[5:1]};
         step(1);
      end
      chk("blocked_busy_window", int'(bvec), int'(6'b011111));
      bus.lane_release = 4'b0100;
      step(1);
      bus.lane_release = 4'b0000;
      chk("release_lane_busy", int'(bus.lane_busy), int'(4'b1011));
      pulse_frame(t);
      push_exp(4'b0001, 11'd300, t + 5);
      step(8);
      chk("post_release_grant_seen", sb.size(), 0);
      chk("post_release_lane_busy", int'(bus.lane_busy), int'(4'b1110));

      // Abandon: request drops in the first probe cycle.
      bus.spawn_req = 4'd0;
      pulse_frame(t);
      step(8);
      pulse_frame(t);
      step(8);
      bus.spawn_req = 4'b0010;
      pulse_frame(t);
      step(1);
      bus.spawn_req = 4'b0000;
      step(1);
      chk("abandon_idle", int'(busy), 0);
      chk("abandon_lane_busy", int'(bus.lane_busy), int'(4'b1110));
      step(5);

      // Restart during probing.
      bus.spawn_req = 4'b0010;
      random        = 11'd1;
      pulse_frame(t);
      step(2);
      game_states = 5'b00001;
      step(1);
      chk("restart_idle", int'(busy), 0);
      chk("restart_lane_busy", int'(bus.lane_busy), 0);
      chk("restart_ack", int'(bus.spawn_ack), 0);
      game_states   = 5'd0;
      bus.spawn_req = 4'd0;
      step(3);

      // Asynchronous reset in the middle of a grant cycle.
      bus.spawn_req = 4'b0001;
      random        = 11'd0;
      pulse_frame(t);
      push_exp(4'b0001, 11'd180, t + 3);
      step(2);
      @(negedge clk);
      #2;
      resetN = 1'b1;
      #1;
      chk("async_ack", int'(bus.spawn_ack), 0);
      chk("async_x", int'(bus.spawn_x), 0);
      chk("async_lane_busy", int'(bus.lane_busy), 0);
      chk("async_busy", int'(busy), 0);
      bus.spawn_req = 4'd0;
      step(2);
      resetN = 1'b0;
      step(2);

      chk("scoreboard_drained", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
